bus_scheduler: RTL and testbench
================================

// Module: bus_scheduler
// PURPOSE
//  Round-robin bus scheduler for the serial bus: shares the single serial channel between two
//  initiator ports and the split target port. Tracks one outstanding split transaction, parks
//  its owner, resumes it after split data return, and revokes hogged grants via a watchdog.
// PARAMETERS
//  TIMEOUT  64  max consecutive cycles one grant may be held; 0 disables watchdog
//  GAP      1   idle cycles inserted after every grant release (0..15)
// PORTS
//  clk            in   1  clock
//  rst_n          in   1  reset, asynchronous, active-low
//  req_1          in   1  initiator 1 bus request (level, held for whole transaction)
//  req_2          in   1  initiator 2 bus request
//  split_req      in   1  split target requests bus to return split data (level)
//  split_start    in   1  1-cycle pulse: current target issued SPLIT to current owner
//  grant_1        out  1  bus granted to initiator 1
//  grant_2        out  1  bus granted to initiator 2
//  grant_split    out  1  bus granted to split target
//  split_pending  out  1  a split transaction is outstanding
//  split_owner    out  2  parked initiator: 2'b01 = init 1, 2'b10 = init 2, 2'b00 = none
//  timeout_err    out  1  1-cycle pulse on watchdog revocation
//  busy           out  1  any grant asserted
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; last-granted pointer = 2 (init 1 wins first tie); masks clear.
//  - All outputs registered; grant_1/grant_2/grant_split one-hot or all zero at every cycle.
//  - States: IDLE, GNT1, GNT2, GNTS, GAP.
//  - IDLE: priority 1) split_req && split_pending -> GNTS; 2) eligible req_1/req_2 -> GNTx,
//    tie broken toward the initiator not last granted. Request sampled cycle N -> grant high N+1.
//  - Eligible = req high, not the parked split_owner, not timeout-masked.
//  - GNTx: hold while req_x high. req_x low -> grant low next cycle, pointer = x, go GAP
//    (or IDLE if GAP=0). Grant is never low for fewer than 1 cycle between owners.
//  - split_start in GNTx with split_pending=0: split_pending<=1, split_owner<=x, grant_x low next
//    cycle, go GAP/IDLE. split_start in any other state or while split_pending=1: ignored.
//  - GNTS: hold while split_req high. split_req low -> split_pending<=0, split_owner<=0; if
//    req_owner high go directly to GNT<owner> next cycle (resume, no gap, bypasses round-robin);
//    else GAP/IDLE.
//  - split_req while split_pending=0: ignored.
//  - GAP: counts GAP cycles with all grants low, then IDLE.
//  - Watchdog: 8-bit-or-wider counter, cleared on entry to any grant state, increments each grant
//    cycle. Reaching TIMEOUT in GNTx: grant low next cycle, timeout_err pulse, pointer = x,
//    initiator x masked until its req drops. In GNTS: grant_split revoked, timeout_err pulse,
//    split_pending/owner cleared, split_req masked until it drops.
//  - Simultaneous: split_start + req drop -> split wins (pending set, no error);
//    timeout + req drop -> normal release, no error; timeout + split_start -> split wins, no error;
//    split_req and req_x in IDLE -> split wins.
//  - Reset mid-operation: grants drop asynchronously; pending split discarded.
// TESTING
//  1. req_1 only -> grant_1 one cycle after req_1; req_1 low -> grant_1 low next cycle, GAP=1 idle.
//  2. req_1=req_2=1 held, each drops after 4 grant cycles and re-raises -> grants alternate 1,2,1,2.
//  3. GNT1, split_start pulse -> grant_1 low, split_owner=01; req_2 -> grant_2; after release,
//     split_req -> grant_split; split_req low -> grant_1 next cycle, split_pending=0.
//  4. TIMEOUT=8, req_2 held forever -> grant_2 high exactly 8 cycles, timeout_err pulse,
//     req_1 then granted; req_2 not re-granted until it toggles low.
//  5. split_req with no split pending, plus req_1 -> grant_1 only; grant_split never asserts.
//  6. rst_n low during GNTS -> all grants 0 immediately, split_pending=0, first grant after is init 1.

Source files
------------

// File: rtl/bus_scheduler.sv
// Round-robin scheduler sharing one serial channel between two initiators and the split target.
// Tracks one outstanding split, parks its owner, resumes it on split data return, and revokes hogged grants.
module bus_scheduler #(
    parameter int TIMEOUT = 64,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_1,
    input  logic       req_2,
    input  logic       split_req,
    input  logic       split_start,
    output logic       grant_1,
    output logic       grant_2,
    output logic       grant_split,
    output logic       split_pending,
    output logic [1:0] split_owner,
    output logic       timeout_err,
    output logic       busy
);

    localparam int WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GNT1,
        ST_GNT2,
        ST_GNTS,
        ST_GAP
    } state_t;

    // Where every grant release lands: the gap counter, or straight back to arbitration.
    localparam state_t ST_REL = (GAP == 0) ? ST_IDLE : ST_GAP;

    state_t          state;
    state_t          state_nx;
    logic            last_2;
    logic            mask_1;
    logic            mask_2;
    logic            mask_s;
    logic [WD_W-1:0] wd_cnt;
    logic [3:0]      gap_cnt;

    logic            elig_1;
    logic            elig_2;
    logic            wd_hit;
    logic            gap_done;
    logic            set_split;
    logic            clr_split;
    logic [1:0]      owner_nx;
    logic            err_nx;
    logic            ptr_upd;
    logic            ptr_nx;
    logic            set_mask_1;
    logic            set_mask_2;
    logic            set_mask_s;

    assign elig_1   = req_1 && !mask_1 && (split_owner != 2'b01);
    assign elig_2   = req_2 && !mask_2 && (split_owner != 2'b10);
    // Counter holds completed grant cycles, so TIMEOUT-1 marks the last permitted cycle.
    assign wd_hit   = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign gap_done = (gap_cnt == 4'(GAP - 1));

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_nx   = state;
        set_split  = 1'b0;
        clr_split  = 1'b0;
        owner_nx   = 2'b00;
        err_nx     = 1'b0;
        ptr_upd    = 1'b0;
        ptr_nx     = last_2;
        set_mask_1 = 1'b0;
        set_mask_2 = 1'b0;
        set_mask_s = 1'b0;

        case (state)
            ST_IDLE: begin
                if (split_req && split_pending && !mask_s) begin
                    state_nx = ST_GNTS;
                end else if (elig_1 && elig_2) begin
                    state_nx = last_2 ? ST_GNT1 : ST_GNT2;
                end else if (elig_1) begin
                    state_nx = ST_GNT1;
                end else if (elig_2) begin
                    state_nx = ST_GNT2;
                end
            end

            ST_GNT1: begin
                // Split beats both a request drop and a watchdog hit in the same cycle.
                if (split_start && !split_pending) begin
                    set_split = 1'b1;
                    owner_nx  = 2'b01;
                    ptr_upd   = 1'b1;
                    ptr_nx    = 1'b0;
                    state_nx  = ST_REL;
                end else if (!req_1) begin
                    ptr_upd  = 1'b1;
                    ptr_nx   = 1'b0;
                    state_nx = ST_REL;
                end else if (wd_hit) begin
                    err_nx     = 1'b1;
                    ptr_upd    = 1'b1;
                    ptr_nx     = 1'b0;
                    set_mask_1 = 1'b1;
                    state_nx   = ST_REL;
                end
            end

            ST_GNT2: begin
                if (split_start && !split_pending) begin
                    set_split = 1'b1;
                    owner_nx  = 2'b10;
                    ptr_upd   = 1'b1;
                    ptr_nx    = 1'b1;
                    state_nx  = ST_REL;
                end else if (!req_2) begin
                    ptr_upd  = 1'b1;
                    ptr_nx   = 1'b1;
                    state_nx = ST_REL;
                end else if (wd_hit) begin
                    err_nx     = 1'b1;
                    ptr_upd    = 1'b1;
                    ptr_nx     = 1'b1;
                    set_mask_2 = 1'b1;
                    state_nx   = ST_REL;
                end
            end

            ST_GNTS: begin
                if (!split_req) begin
                    clr_split = 1'b1;
                    // The parked owner resumes immediately, skipping gap and round-robin.
                    if (split_owner == 2'b01 && req_1) begin
                        state_nx = ST_GNT1;
                    end else if (split_owner == 2'b10 && req_2) begin
                        state_nx = ST_GNT2;
                    end else begin
                        state_nx = ST_REL;
                    end
                end else if (wd_hit) begin
                    err_nx     = 1'b1;
                    clr_split  = 1'b1;
                    set_mask_s = 1'b1;
                    state_nx   = ST_REL;
                end
            end

            ST_GAP: begin
                if (gap_done) begin
                    state_nx = ST_IDLE;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments only, and the async reset drops grants at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            last_2        <= 1'b1;
            mask_1        <= 1'b0;
            mask_2        <= 1'b0;
            mask_s        <= 1'b0;
            wd_cnt        <= '0;
            gap_cnt       <= 4'd0;
            grant_1       <= 1'b0;
            grant_2       <= 1'b0;
            grant_split   <= 1'b0;
            split_pending <= 1'b0;
            split_owner   <= 2'b00;
            timeout_err   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state       <= state_nx;
            grant_1     <= (state_nx == ST_GNT1);
            grant_2     <= (state_nx == ST_GNT2);
            grant_split <= (state_nx == ST_GNTS);
            busy        <= (state_nx == ST_GNT1) || (state_nx == ST_GNT2) || (state_nx == ST_GNTS);
            timeout_err <= err_nx;

            if (state_nx != state) begin
                wd_cnt <= '0;
            end else if (state == ST_GNT1 || state == ST_GNT2 || state == ST_GNTS) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            gap_cnt <= (state == ST_GAP) ? gap_cnt + 4'd1 : 4'd0;

            if (set_split) begin
                split_pending <= 1'b1;
                split_owner   <= owner_nx;
            end else if (clr_split) begin
                split_pending <= 1'b0;
                split_owner   <= 2'b00;
            end

            if (ptr_upd) begin
                last_2 <= ptr_nx;
            end

            // A watchdog mask lasts until the offending request is withdrawn.
            mask_1 <= req_1 && (mask_1 || set_mask_1);
            mask_2 <= req_2 && (mask_2 || set_mask_2);
            mask_s <= split_req && (mask_s || set_mask_s);
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// Bench for bus_scheduler: directed scenarios plus randomized traffic compared cycle by cycle
// against an owner/cooldown reference model of the scheduling rules.
module tb_bus_scheduler;

    localparam int TIMEOUT_P = 8;
    localparam int GAP_P     = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_1 = 1'b0;
    logic       req_2 = 1'b0;
    logic       split_req = 1'b0;
    logic       split_start = 1'b0;
    logic       grant_1;
    logic       grant_2;
    logic       grant_split;
    logic       split_pending;
    logic [1:0] split_owner;
    logic       timeout_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    bus_scheduler #(.TIMEOUT(TIMEOUT_P), .GAP(GAP_P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_1        (req_1),
        .req_2        (req_2),
        .split_req    (split_req),
        .split_start  (split_start),
        .grant_1      (grant_1),
        .grant_2      (grant_2),
        .grant_split  (grant_split),
        .split_pending(split_pending),
        .split_owner  (split_owner),
        .timeout_err  (timeout_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout: time %0t, required finish before 200000", $time);
        $fatal(1, "bench did not terminate");
    end

    // Reference model: who owns the bus (0 none, 1, 2, 3 split), how long, and the idle cooldown.
    int m_owner, m_held, m_cool, m_last, m_park;
    bit m_pend, m_err, m_blk1, m_blk2, m_blks;

    task automatic model_reset();
        m_owner = 0; m_held = 0; m_cool = 0; m_last = 2; m_park = 0;
        m_pend = 0; m_err = 0; m_blk1 = 0; m_blk2 = 0; m_blks = 0;
    endtask

    task automatic model_release();
        m_owner = 0;
        m_cool  = GAP_P;
    endtask

    task automatic model_edge(input bit r1, input bit r2, input bit sr, input bit ss);
        bit e1, e2, rx, expired;
        int p;
        m_err   = 0;
        expired = (TIMEOUT_P != 0) && (m_held == TIMEOUT_P);
        if (m_owner == 0) begin
            if (m_cool > 0) begin
                m_cool--;
            end else if (sr && m_pend && !m_blks) begin
                m_owner = 3; m_held = 1;
            end else begin
                e1 = r1 && !m_blk1 && (m_park != 1);
                e2 = r2 && !m_blk2 && (m_park != 2);
                if (e1 && e2) m_owner = (m_last == 2) ? 1 : 2;
                else if (e1)  m_owner = 1;
                else if (e2)  m_owner = 2;
                m_held = 1;
            end
        end else if (m_owner == 3) begin
            if (!sr) begin
                p = m_park; m_pend = 0; m_park = 0;
                if ((p == 1 && r1) || (p == 2 && r2)) begin
                    m_owner = p; m_held = 1;
                end else begin
                    model_release();
                end
            end else if (expired) begin
                m_err = 1; m_pend = 0; m_park = 0; m_blks = 1;
                model_release();
            end else begin
                m_held++;
            end
        end else begin
            rx = (m_owner == 1) ? r1 : r2;
            if (ss && !m_pend) begin
                m_pend = 1; m_park = m_owner; m_last = m_owner;
                model_release();
            end else if (!rx) begin
                m_last = m_owner;
                model_release();
            end else if (expired) begin
                m_err = 1; m_last = m_owner;
                if (m_owner == 1) m_blk1 = 1; else m_blk2 = 1;
                model_release();
            end else begin
                m_held++;
            end
        end
        if (!r1) m_blk1 = 0;
        if (!r2) m_blk2 = 0;
        if (!sr) m_blks = 0;
    endtask

    function automatic logic [7:0] dut_vec();
        return {grant_1, grant_2, grant_split, split_pending, split_owner, timeout_err, busy};
    endfunction

    function automatic logic [7:0] mdl_vec();
        logic [1:0] po;
        po = (m_park == 1) ? 2'b01 : (m_park == 2) ? 2'b10 : 2'b00;
        return {m_owner == 1, m_owner == 2, m_owner == 3, m_pend, po, m_err, m_owner != 0};
    endfunction

    function automatic logic [3:0] gvec();
        return {grant_1, grant_2, grant_split, busy};
    endfunction

    function automatic logic sel(input int which);
        case (which)
            1:       return grant_1;
            2:       return grant_2;
            3:       return grant_split;
            default: return busy;
        endcase
    endfunction

    // One clock: model consumes the inputs seen at the edge, outputs are then sampled at negedge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(req_1, req_2, split_req, split_start);
        @(negedge clk);
    endtask

    task automatic wait_for(input int which, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sel(which)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_1 = 0; req_2 = 0; split_req = 0; split_start = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec() !== 8'h00) $display("FAIL reset_outputs: got %b, expected %b", dut_vec(), 8'h00);
        else n_pass++;
        step();
        n_checks++;
        if (dut_vec() !== 8'h00) $display("FAIL idle_outputs: got %b, expected %b", dut_vec(), 8'h00);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        req_1 = 1;
        step();
        n_checks++;
        if (gvec() !== 4'b1001) $display("FAIL single_grant: got %b, expected %b", gvec(), 4'b1001);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (gvec() !== 4'b1001) $display("FAIL single_hold: got %b, expected %b", gvec(), 4'b1001);
        else n_pass++;
        req_1 = 0;
        step();
        n_checks++;
        if (gvec() !== 4'b0000) $display("FAIL single_release: got %b, expected %b", gvec(), 4'b0000);
        else n_pass++;
        req_1 = 1;
        step();
        n_checks++;
        if (gvec() !== 4'b0000) $display("FAIL single_gap: got %b, expected %b", gvec(), 4'b0000);
        else n_pass++;
        step();
        n_checks++;
        if (gvec() !== 4'b1001) $display("FAIL single_regrant: got %b, expected %b", gvec(), 4'b1001);
        else n_pass++;
        req_1 = 0;
        repeat (3) step();
    endtask

    task automatic test_round_robin();
        int order[$];
        int exp_o[4] = '{1, 2, 1, 2};
        int h1, h2, got;
        bit p1, p2;
        do_reset();
        req_1 = 1; req_2 = 1;
        h1 = 0; h2 = 0; p1 = 0; p2 = 0;
        for (int i = 0; i < 80 && order.size() < 4; i++) begin
            step();
            if (grant_1) begin
                if (!p1) begin order.push_back(1); h1 = 0; end
                h1++;
                if (h1 == 4) req_1 = 0;
            end else if (!req_1) begin
                req_1 = 1;
            end
            if (grant_2) begin
                if (!p2) begin order.push_back(2); h2 = 0; end
                h2++;
                if (h2 == 4) req_2 = 0;
            end else if (!req_2) begin
                req_2 = 1;
            end
            p1 = grant_1; p2 = grant_2;
        end
        for (int k = 0; k < 4; k++) begin
            got = (k < order.size()) ? order[k] : 0;
            n_checks++;
            if (got !== exp_o[k]) $display("FAIL rr_order[%0d]: got %0d, expected %0d", k, got, exp_o[k]);
            else n_pass++;
        end
        req_1 = 0; req_2 = 0;
        repeat (4) step();
    endtask

    task automatic test_split();
        bit ok;
        do_reset();
        req_1 = 1;
        wait_for(1, 10, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL split_first_grant: got %0d, expected 1", ok);
        else n_pass++;
        split_start = 1;
        step();
        split_start = 0;
        n_checks++;
        if ({grant_1, split_pending, split_owner} !== 4'b0101)
            $display("FAIL split_park: got %b, expected %b", {grant_1, split_pending, split_owner}, 4'b0101);
        else n_pass++;
        req_2 = 1;
        wait_for(2, 10, ok);
        n_checks++;
        if ({ok, grant_1} !== 2'b10) $display("FAIL split_other_grant: got %b, expected %b", {ok, grant_1}, 2'b10);
        else n_pass++;
        req_2 = 0;
        repeat (2) step();
        split_req = 1;
        wait_for(3, 10, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL split_data_grant: got %0d, expected 1", ok);
        else n_pass++;
        split_req = 0;
        step();
        n_checks++;
        if ({grant_1, grant_split, split_pending, split_owner} !== 5'b10000)
            $display("FAIL split_resume: got %b, expected %b",
                     {grant_1, grant_split, split_pending, split_owner}, 5'b10000);
        else n_pass++;
        req_1 = 0;
        repeat (4) step();
    endtask

    task automatic test_timeout();
        bit ok, seen2;
        int cnt;
        do_reset();
        req_2 = 1;
        wait_for(2, 10, ok);
        cnt = ok ? 1 : 0;
        for (int i = 0; i < 20 && ok; i++) begin
            step();
            if (grant_2) cnt++;
            else break;
        end
        n_checks++;
        if (cnt !== TIMEOUT_P) $display("FAIL timeout_hold: got %0d cycles, expected %0d", cnt, TIMEOUT_P);
        else n_pass++;
        n_checks++;
        if ({timeout_err, grant_2} !== 2'b10)
            $display("FAIL timeout_err: got %b, expected %b", {timeout_err, grant_2}, 2'b10);
        else n_pass++;
        req_1 = 1;
        wait_for(1, 10, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL timeout_other_grant: got %0d, expected 1", ok);
        else n_pass++;
        req_1 = 0;
        seen2 = 0;
        repeat (12) begin
            step();
            if (grant_2) seen2 = 1;
        end
        n_checks++;
        if (seen2 !== 1'b0) $display("FAIL timeout_mask: got %0d, expected 0", seen2);
        else n_pass++;
        req_2 = 0;
        step();
        req_2 = 1;
        wait_for(2, 10, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL timeout_unmask: got %0d, expected 1", ok);
        else n_pass++;
        req_2 = 0;
        repeat (4) step();
    endtask

    task automatic test_split_ignored();
        bit seen_s, seen_1;
        do_reset();
        split_req = 1; req_1 = 1;
        seen_s = 0; seen_1 = 0;
        repeat (6) begin
            step();
            if (grant_split) seen_s = 1;
            if (grant_1) seen_1 = 1;
        end
        n_checks++;
        if ({seen_1, seen_s, split_pending} !== 3'b100)
            $display("FAIL split_ignored: got %b, expected %b", {seen_1, seen_s, split_pending}, 3'b100);
        else n_pass++;
        req_1 = 0; split_req = 0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        req_1 = 1;
        wait_for(1, 10, ok);
        split_start = 1; split_req = 1;
        step();
        split_start = 0;
        wait_for(3, 10, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rstmid_split_grant: got %0d, expected 1", ok);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== 8'h00) $display("FAIL rstmid_async: got %b, expected %b", dut_vec(), 8'h00);
        else n_pass++;
        model_reset();
        req_2 = 1; split_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for(4, 10, ok);
        n_checks++;
        if ({ok, grant_1, grant_2} !== 3'b110)
            $display("FAIL rstmid_first_grant: got %b, expected %b", {ok, grant_1, grant_2}, 3'b110);
        else n_pass++;
        req_1 = 0; req_2 = 0;
        repeat (4) step();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) req_1 = !req_1;
            if ($urandom_range(7) == 0) req_2 = !req_2;
            if ($urandom_range(5) == 0) split_req = !split_req;
            split_start = ($urandom_range(4) == 0);
            step();
            n_checks++;
            if (dut_vec() !== mdl_vec())
                $display("FAIL random[%0d]: got %b, expected %b", i, dut_vec(), mdl_vec());
            else n_pass++;
        end
        split_start = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_split();
        test_timeout();
        test_split_ignored();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
